// File: rtl/button_event_gen_if.sv
// Signal bundle between a debounced button source and its event generator.
// The slave side (the generator) consumes btn_level and produces the event outputs.
interface button_event_gen_if;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  btn_level,
        output press_pulse,
        output release_pulse,
        output long_press,
        output repeat_pulse,
        output held
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns a debounced, clk-synchronous button level into single-cycle press/release/long/repeat events.
// Auto-repeat is built only when BTN_EVT_REPEAT_EN is defined; otherwise repeat_pulse is tied to 0.
module button_event_gen #(
    parameter int unsigned HOLD_CYCLES   = 100_000_000,
    parameter int unsigned REPEAT_CYCLES = 25_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic                clk,
    input  logic                reset,
    button_event_gen_if.slave   bus
);

    localparam logic [1:0] StWaitLow = 2'd0;
    localparam logic [1:0] StIdle    = 2'd1;
    localparam logic [1:0] StHeld    = 2'd2;
    localparam logic [1:0] StRepeat  = 2'd3;

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam longint           CntMax   = (longint'(1) << CNT_W) - 1;

    // Reject terminal counts that cannot be represented in the counter.
    if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > CntMax) begin : g_bad_hold
        $error("button_event_gen: HOLD_CYCLES out of range for CNT_W");
    end
    if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) > CntMax) begin : g_bad_repeat
        $error("button_event_gen: REPEAT_CYCLES out of range for CNT_W");
    end

`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             held_q, held_d;
`ifdef BTN_EVT_REPEAT_EN
    logic             repeat_q, repeat_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef BTN_EVT_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        unique case (state_q)
            // A button held through reset must be seen low before it can press.
            StWaitLow: begin
                if (!bus.btn_level) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (bus.btn_level) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            StHeld: begin
                if (!bus.btn_level) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == HoldLast) begin
                    state_d  = StRepeat;
                    cnt_d    = '0;
                    long_d   = 1'b1;
`ifdef BTN_EVT_REPEAT_EN
                    repeat_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRepeat: begin
                if (!bus.btn_level) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef BTN_EVT_REPEAT_EN
                    if (cnt_q == RepeatLast) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = StWaitLow;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == StHeld) || (state_d == StRepeat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StWaitLow;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
`ifdef BTN_EVT_REPEAT_EN
            repeat_q  <= repeat_d;
`endif
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_press    = long_q;
    assign bus.held          = held_q;
`ifdef BTN_EVT_REPEAT_EN
    assign bus.repeat_pulse  = repeat_q;
`else
    assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Directed plus randomized bench for button_event_gen, checked against a press-timeline model.
module tb_button_event_gen;

    localparam int unsigned HOLD   = 8;
    localparam int unsigned REPEAT = 4;
`ifdef BTN_EVT_REPEAT_EN
    localparam bit RepOn = 1'b1;
`else
    localparam bit RepOn = 1'b0;
`endif

    logic clk;
    logic reset;
    button_event_gen_if bus ();

    button_event_gen #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT),
        .CNT_W         (27)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: armed = button seen low since reset; t = edges elapsed since the press edge.
    bit armed   = 1'b0;
    bit pressed = 1'b0;
    int t       = 0;

    int n_press, n_rel, n_long, n_rep;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic b, input logic r);
        logic e_press, e_rel, e_long, e_rep, e_held;
        @(negedge clk);
        bus.btn_level = b;
        reset         = r;
        @(posedge clk);
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (r) begin
            armed   = 1'b0;
            pressed = 1'b0;
        end else if (!armed) begin
            if (!b) armed = 1'b1;
        end else if (!pressed) begin
            if (b) begin
                pressed = 1'b1;
                t       = 0;
                e_press = 1'b1;
            end
        end else begin
            t++;
            if (!b) begin
                pressed = 1'b0;
                e_rel   = 1'b1;
            end else if (t == HOLD) begin
                e_long = 1'b1;
                e_rep  = RepOn;
            end else if (t > HOLD && ((t - HOLD) % REPEAT) == 0) begin
                e_rep = RepOn;
            end
        end
        e_held = pressed;
        #1;
        chk("press_pulse",   bus.press_pulse,   e_press);
        chk("release_pulse", bus.release_pulse, e_rel);
        chk("long_press",    bus.long_press,    e_long);
        chk("repeat_pulse",  bus.repeat_pulse,  e_rep);
        chk("held",          bus.held,          e_held);
        chk("press_release_overlap", bus.press_pulse & bus.release_pulse, 1'b0);
        n_press += int'(bus.press_pulse);
        n_rel   += int'(bus.release_pulse);
        n_long  += int'(bus.long_press);
        n_rep   += int'(bus.repeat_pulse);
    endtask

    task automatic clear_counts();
        n_press = 0;
        n_rel   = 0;
        n_long  = 0;
        n_rep   = 0;
    endtask

    task automatic drive(input logic b, input int n);
        for (int i = 0; i < n; i++) cycle(b, 1'b0);
    endtask

    initial begin
        logic lvl;
        reset         = 1'b1;
        bus.btn_level = 1'b0;
        clear_counts();

        // Reset state
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        drive(1'b0, 2);

        // Short press
        clear_counts();
        drive(1'b1, 3);
        drive(1'b0, 3);
        chk_int("short_press_count",   n_press, 1);
        chk_int("short_release_count", n_rel,   1);
        chk_int("short_long_count",    n_long,  0);
        chk_int("short_repeat_count",  n_rep,   0);

        // Long hold of 20 cycles
        clear_counts();
        drive(1'b1, 20);
        drive(1'b0, 3);
        chk_int("long_hold_long_count",   n_long, 1);
        chk_int("long_hold_repeat_count", n_rep,  RepOn ? 3 : 0);
        chk_int("long_hold_release",      n_rel,  1);

        // Release on the hold terminal edge
        clear_counts();
        drive(1'b1, HOLD);
        drive(1'b0, 2);
        chk_int("term_release_count", n_rel,  1);
        chk_int("term_long_count",    n_long, 0);

        // Release on a repeat terminal edge
        clear_counts();
        drive(1'b1, HOLD + REPEAT);
        drive(1'b0, 2);
        chk_int("rep_term_repeat_count", n_rep, RepOn ? 1 : 0);

        // Reset while held, button stays high through and after reset
        clear_counts();
        drive(1'b1, 3);
        cycle(1'b1, 1'b1);
        drive(1'b1, 10);
        chk_int("abort_no_release", n_rel, 0);
        drive(1'b0, 1);
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk_int("abort_press_count", n_press, 2);
        chk_int("abort_release_count", n_rel, 1);

        // Back-to-back single-cycle presses
        clear_counts();
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b0, 1);
        chk_int("b2b_press_count",   n_press, 2);
        chk_int("b2b_release_count", n_rel,   2);

        // Randomized runs with occasional resets
        lvl = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            len = int'($urandom_range(1, 18));
            lvl = ~lvl;
            for (int i = 0; i < len; i++) begin
                cycle(lvl, ($urandom_range(0, 63) == 0));
            end
        end
        drive(1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
